// File: rtl/mlp_axis_layer_if.sv
`timescale 1ns/1ps
// AXI-Stream operand channel feeding the MLP layer engine.
// The master drives data, valid and last; the slave (the layer) drives ready.
interface mlp_axis_layer_if #(
   parameter int TDATA_W = 32
) ();
   logic [TDATA_W-1:0] s00_axis_tdata;
   logic               s00_axis_tvalid;
   logic               s00_axis_tready;
   logic               s00_axis_tlast;

   modport master (
      output s00_axis_tdata,
      output s00_axis_tvalid,
      output s00_axis_tlast,
      input  s00_axis_tready
   );

   modport slave (
      input  s00_axis_tdata,
      input  s00_axis_tvalid,
      input  s00_axis_tlast,
      output s00_axis_tready
   );
endinterface

// File: rtl/mlp_axis_layer.sv
`timescale 1ns/1ps
// mlp_axis_layer: fully-connected layer engine.
// Streams in one activation vector, then weights and bias for every neuron,
// accumulates in full precision, saturates, stores each neuron output and
// tracks the arg-max index. Define MLP_RELU_EN to clip negative outputs to 0.
module mlp_axis_layer #(
   parameter int WIDTH     = 18,
   parameter int FRAC_BITS = 8,
   parameter int IN_LEN    = 784,
   parameter int NEURONS   = 30,
   parameter int TDATA_W   = 32,
   localparam int CL_W     = ($clog2(NEURONS) > 1) ? $clog2(NEURONS) : 1,
   localparam int ADDR_W   = $clog2(NEURONS)
) (
   input  logic                    s00_axis_aclk,
   input  logic                    s00_axis_areset,
   input  logic                    start,
   output logic                    ready,
   output logic                    err,
   output logic [CL_W-1:0]         cl_num,
   input  logic [ADDR_W-1:0]       res_addr,
   output logic signed [WIDTH-1:0] res_data,
   mlp_axis_layer_if.slave         axis
);
   localparam int ACC_W = 2 * WIDTH + $clog2(IN_LEN + 1);
   localparam int IDX_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_X, S_LOAD_W, S_LOAD_B, S_STORE, S_DONE
   } state_t;

   state_t                   state, state_nxt;
   logic                     start_q, start_pulse;
   logic [IDX_W-1:0]         idx;
   logic [CL_W-1:0]          n;
   logic signed [WIDTH-1:0]  x_buf [IN_LEN];
   logic signed [WIDTH-1:0]  results [NEURONS];
   logic signed [ACC_W-1:0]  acc;
   logic signed [WIDTH-1:0]  best;

   logic                     beat, launch, last_x, last_n, exp_last, take_best;
   logic signed [WIDTH-1:0]  d_in, x_sel, y_st;
   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext, bias_ext;
   logic                     unused_tdata;

   // Clamp a full-precision value into the signed WIDTH-bit output range.
   function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] y_max, y_min;
      y_max = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
      y_min = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
      if (v > y_max)      return y_max[WIDTH-1:0];
      else if (v < y_min) return y_min[WIDTH-1:0];
      else                return v[WIDTH-1:0];
   endfunction

   // Optional rectifier applied after saturation.
   function automatic logic signed [WIDTH-1:0] act_w(input logic signed [WIDTH-1:0] v);
`ifdef MLP_RELU_EN
      return v[WIDTH-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   assign unused_tdata = ^axis.s00_axis_tdata;
   assign d_in      = axis.s00_axis_tdata[WIDTH-1:0];
   assign beat      = axis.s00_axis_tvalid & axis.s00_axis_tready;
   assign launch    = start_pulse & ((state == S_IDLE) | (state == S_DONE));
   assign last_x    = (idx == IDX_W'(IN_LEN - 1));
   assign last_n    = (n == CL_W'(NEURONS - 1));
   assign exp_last  = (state == S_LOAD_B) & last_n;
   assign x_sel     = x_buf[idx];
   assign prod      = {{WIDTH{x_sel[WIDTH-1]}}, x_sel} * {{WIDTH{d_in[WIDTH-1]}}, d_in};
   assign prod_ext  = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
   assign bias_ext  = {{(ACC_W-WIDTH){d_in[WIDTH-1]}}, d_in};
   assign y_st      = act_w(sat_w(acc >>> FRAC_BITS));
   assign take_best = (n == '0) | (y_st > best);

   // State register.
   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) state <= S_IDLE;
      else                 state <= state_nxt;
   end

   // Next-state decode; ready and tready are pure decodes of the state register.
   always_comb begin
      state_nxt            = state;
      ready                = 1'b0;
      axis.s00_axis_tready = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            ready = 1'b1;
            if (launch) state_nxt = S_LOAD_X;
         end
         S_LOAD_X: begin
            axis.s00_axis_tready = 1'b1;
            if (beat && last_x) state_nxt = S_LOAD_W;
         end
         S_LOAD_W: begin
            axis.s00_axis_tready = 1'b1;
            if (beat && last_x) state_nxt = S_LOAD_B;
         end
         S_LOAD_B: begin
            axis.s00_axis_tready = 1'b1;
            if (beat) state_nxt = S_STORE;
         end
         S_STORE: state_nxt = last_n ? S_DONE : S_LOAD_W;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control: start edge detect, beat/neuron counters, framing error, arg-max index.
   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         start_q     <= 1'b0;
         start_pulse <= 1'b0;
         idx         <= '0;
         n           <= '0;
         err         <= 1'b0;
         cl_num      <= '0;
      end else begin
         start_q     <= start;
         start_pulse <= start & ~start_q;
         if (launch) begin
            idx <= '0;
            n   <= '0;
            err <= 1'b0;
         end else begin
            if (beat) begin
               if (axis.s00_axis_tlast != exp_last) err <= 1'b1;
               if ((state == S_LOAD_X) || (state == S_LOAD_W))
                  idx <= last_x ? '0 : idx + IDX_W'(1);
            end
            if (state == S_STORE) begin
               n <= last_n ? '0 : n + CL_W'(1);
               if (take_best) cl_num <= n;
            end
         end
      end
   end

   // Result store and registered read port; out-of-range reads return zero.
   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         for (int i = 0; i < NEURONS; i++) results[i] <= '0;
         res_data <= '0;
      end else begin
         if (state == S_STORE) results[n] <= y_st;
         res_data <= (int'(res_addr) < NEURONS) ? results[res_addr] : '0;
      end
   end

   // Datapath: activation buffer, multiply-accumulate, best-value tracking.
   always_ff @(posedge s00_axis_aclk) begin
      if (launch) begin
         acc <= '0;
      end else begin
         case (state)
            S_LOAD_X: if (beat) x_buf[idx] <= d_in;
            S_LOAD_W: if (beat) acc <= acc + prod_ext;
            S_LOAD_B: if (beat) acc <= acc + (bias_ext <<< FRAC_BITS);
            S_STORE: begin
               acc <= '0;
               if (take_best) best <= y_st;
            end
            default: ;
         endcase
      end
   end
endmodule
